// File: rtl/mic_capture_ctrl.sv
// mic_capture_ctrl
//   Capture sequencer for a PDM microphone. Generates the mic clock, throws away
//   WARMUP whole windows after each start, then decimates M_DATA by counting ones
//   over WINDOW-bit windows. Each window result is offered on a valid/ready port.
//   Runs finite bursts of num_samples windows, or continuous capture when
//   num_samples is 0.
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   enable           capture permitted; dropping it aborts the current run
//   start            one-cycle request to begin a run (ignored while busy)
//   num_samples      windows to capture, 0 = continuous; latched on accepted start
//   M_DATA           PDM bit stream from the mic
//   M_CLK, M_LRSEL   mic clock and constant channel select
//   busy, done       run in progress / one-cycle pulse at normal end of a finite run
//   sample,
//   sample_valid,
//   sample_ready     window result handshake
//   overrun,
//   clear_overrun    sticky flag for dropped window results, and its clear
module mic_capture_ctrl #(
    parameter int unsigned CLK_DIV  = 25,
    parameter int unsigned WINDOW   = 128,
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned WARMUP   = 4,
    parameter bit          LRSEL    = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                start,
    input  logic [15:0]         num_samples,
    input  logic                M_DATA,
    output logic                M_CLK,
    output logic                M_LRSEL,
    output logic                busy,
    output logic                done,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    input  logic                clear_overrun
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BitW = $clog2(WINDOW);

    typedef enum logic [1:0] {StIdle, StWarmup, StCapture, StFinish} state_e;

    state_e              state_q, state_d;
    logic [DivW-1:0]     div_q;
    logic                m_clk_q;
    logic [BitW-1:0]     bit_q;
    logic [SAMPLE_W-1:0] acc_q;
    logic [15:0]         win_q;
    logic [15:0]         num_q;
    logic [SAMPLE_W-1:0] sample_q;
    logic                valid_q;
    logic                overrun_q;
    logic                done_q;

    logic                running;
    logic                div_wrap;
    logic                bit_tick;
    logic                win_end;
    logic                warm_last;
    logic                cap_last;
    logic                load;
    logic                drop;
    logic [SAMPLE_W-1:0] result;

    // Clocking only continues while enable holds; an abort clears everything next edge.
    assign running   = ((state_q == StWarmup) || (state_q == StCapture)) && enable;
    assign div_wrap  = running && (div_q == DivW'(CLK_DIV - 1));
    // Sample on the last system cycle before the falling edge of M_CLK.
    assign bit_tick  = div_wrap && m_clk_q;
    assign win_end   = bit_tick && (bit_q == BitW'(WINDOW - 1));
    assign result    = acc_q + SAMPLE_W'(M_DATA);
    assign warm_last = (win_q == 16'(WARMUP - 1));
    assign cap_last  = (num_q != 16'd0) && (win_q == num_q - 16'd1);
    assign load      = (state_q == StCapture) && running && win_end
                       && (!valid_q || sample_ready);
    assign drop      = (state_q == StCapture) && running && win_end
                       && valid_q && !sample_ready;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && enable) begin
                    state_d = (WARMUP == 0) ? StCapture : StWarmup;
                end
            end
            StWarmup: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (win_end && warm_last) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (win_end && cap_last) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                if (!enable || !valid_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM / registered outputs
    always_comb begin
        busy         = (state_q != StIdle);
        done         = done_q;
        M_CLK        = m_clk_q;
        M_LRSEL      = LRSEL;
        sample       = sample_q;
        sample_valid = valid_q;
        overrun      = overrun_q;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= '0;
            m_clk_q   <= 1'b0;
            bit_q     <= '0;
            acc_q     <= '0;
            win_q     <= '0;
            num_q     <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (running) begin
                if (div_wrap) begin
                    div_q   <= '0;
                    m_clk_q <= ~m_clk_q;
                end else begin
                    div_q <= div_q + 1'b1;
                end
            end else begin
                div_q   <= '0;
                m_clk_q <= 1'b0;
            end

            if (!running) begin
                bit_q <= '0;
                acc_q <= '0;
                win_q <= '0;
            end else if (win_end) begin
                bit_q <= '0;
                acc_q <= '0;
                // The window count restarts when warm-up hands over to capture.
                win_q <= ((state_q == StWarmup) && warm_last) ? 16'd0 : win_q + 16'd1;
            end else if (bit_tick) begin
                bit_q <= bit_q + 1'b1;
                acc_q <= result;
            end

            if ((state_q == StIdle) && start && enable) begin
                num_q <= num_samples;
            end

            if (load) begin
                sample_q <= result;
                valid_q  <= 1'b1;
            end else if (valid_q && sample_ready) begin
                valid_q <= 1'b0;
            end

            // A drop in the same cycle as a clear wins.
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun) begin
                overrun_q <= 1'b0;
            end

            done_q <= (state_q == StFinish) && enable && !valid_q;
        end
    end

endmodule
